// File: rtl/voltage_to_dac_code_pkg.sv
// rtl/voltage_to_dac_code_pkg.sv - shared calibration constants, widths and FSM states
//
// Purpose: board calibration constants shared by the DAC (voltage -> code)
// and ADC (code -> voltage) paths so both directions stay consistent, plus
// the divider operand widths and the conversion state enum.
// Ports: none (package).
package voltage_cal_pkg;

    // Calibration constants, voltages in volts x100, factors in x100 fixed point.
    localparam int unsigned REF_VOLTAGE = 500;
    localparam int unsigned DAC_MAX     = 255;
    localparam int unsigned SCALE_BASE  = 100;
    localparam int unsigned SCALE_MIN   = 132;
    localparam int unsigned SCALE_MAX   = 133;
    localparam int unsigned V_MIN       = 100;
    localparam int unsigned V_MAX       = 500;

    // Divider operand widths and iteration count (one quotient bit per cycle).
    localparam int NUM_W     = 24;
    localparam int DEN_W     = 17;
    localparam int DIV_ITERS = NUM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/voltage_to_dac_code_if.sv
// rtl/voltage_to_dac_code_if.sv - request/result bundle for voltage_to_dac_code
//
// Purpose: groups the voltage request handshake and the DAC code result.
// Signals:
//   voltage_in [15:0] requested voltage, volts x100
//   in_valid          voltage_in is valid
//   in_ready          converter idle, request accepted on in_valid && in_ready
//   dac_code   [7:0]  calibrated DAC code, held until the next result
//   dac_valid         one-cycle strobe marking a new dac_code
//   clipped           last request was clamped to the reference voltage
// Modports: master drives the request, slave (the converter) drives results.
interface voltage_to_dac_code_if;
    logic [15:0] voltage_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  dac_code;
    logic        dac_valid;
    logic        clipped;

    modport master (
        output voltage_in, in_valid,
        input  in_ready, dac_code, dac_valid, clipped
    );

    modport slave (
        input  voltage_in, in_valid,
        output in_ready, dac_code, dac_valid, clipped
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
//
// Purpose: computes i_dividend / i_divisor (24-bit / 17-bit) over 24 cycles.
// The first iteration is performed on the i_start edge itself, so o_done is
// high for one cycle starting 23 edges after the start edge, with
// o_quotient stable from then until the next start.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   i_start     load operands and begin (restarts an ongoing division)
//   i_dividend  24-bit numerator
//   i_divisor   17-bit denominator, must be non-zero
//   o_quotient  24-bit quotient
//   o_done      one-cycle completion strobe
module seq_divider
    import voltage_cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_dividend,
    input  logic [DEN_W-1:0] i_divisor,
    output logic [NUM_W-1:0] o_quotient,
    output logic             o_done
);

    logic [DEN_W-1:0] r_rem;
    logic [NUM_W-1:0] r_quo;   // dividend bits shift out the top, quotient bits in the bottom
    logic [DEN_W-1:0] r_den;
    logic [4:0]       r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [DEN_W-1:0] w_rem_in;
    logic [NUM_W-1:0] w_quo_in;
    logic [DEN_W-1:0] w_den_in;
    logic [DEN_W:0]   w_shift;
    logic             w_fits;
    logic [DEN_W-1:0] w_rem_next;
    logic [NUM_W-1:0] w_quo_next;

    // On start the step works on the fresh operands so no cycle is spent loading.
    assign w_rem_in   = i_start ? '0 : r_rem;
    assign w_quo_in   = i_start ? i_dividend : r_quo;
    assign w_den_in   = i_start ? i_divisor : r_den;

    assign w_shift    = {w_rem_in, w_quo_in[NUM_W-1]};
    assign w_fits     = (w_shift >= {1'b0, w_den_in});
    // When the divisor fits, the difference is below the divisor and fits DEN_W bits.
    assign w_rem_next = w_fits ? DEN_W'(w_shift - {1'b0, w_den_in}) : w_shift[DEN_W-1:0];
    assign w_quo_next = {w_quo_in[NUM_W-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_den  <= i_divisor;
                r_cnt  <= 5'(DIV_ITERS - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quotient = r_quo;
    assign o_done     = r_done;

endmodule

// File: rtl/voltage_to_dac_code.sv
// rtl/voltage_to_dac_code.sv - calibrated voltage to PCF8591 DAC code converter
//
// Purpose: clamps the requested voltage to the reference, applies the inverse
// of the board calibration (interpolated scale factor) and divides with
// round-half-up to produce the 8-bit DAC code. One conversion every 27 cycles.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, aborts any conversion in flight
//   bus  voltage_to_dac_code_if.slave: voltage_in/in_valid/in_ready request,
//        dac_code/dac_valid/clipped result
module voltage_to_dac_code #(
    parameter int unsigned REF_VOLTAGE = voltage_cal_pkg::REF_VOLTAGE,
    parameter int unsigned DAC_MAX     = voltage_cal_pkg::DAC_MAX,
    parameter int unsigned SCALE_BASE  = voltage_cal_pkg::SCALE_BASE,
    parameter int unsigned SCALE_MIN   = voltage_cal_pkg::SCALE_MIN,
    parameter int unsigned SCALE_MAX   = voltage_cal_pkg::SCALE_MAX,
    parameter int unsigned V_MIN       = voltage_cal_pkg::V_MIN,
    parameter int unsigned V_MAX       = voltage_cal_pkg::V_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    voltage_to_dac_code_if.slave   bus
);
    import voltage_cal_pkg::*;

    state_t           r_state;
    state_t           w_next;

    logic [15:0]      r_v;          // clamped request
    logic             r_clip_pend;  // clip flag of the conversion in flight
    logic [7:0]       r_dac_code;
    logic             r_dac_valid;
    logic             r_clipped;

    logic             w_accept;
    logic             w_over;
    logic [31:0]      w_v32;
    logic [31:0]      w_scale;
    logic [DEN_W-1:0] w_den;
    logic [NUM_W-1:0] w_num;
    logic [NUM_W-1:0] w_quotient;
    logic             w_div_done;
    logic [7:0]       w_code;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_over   = ({16'd0, bus.voltage_in} > REF_VOLTAGE);

    // Calibration factor, linearly interpolated between V_MIN and V_MAX (truncating).
    assign w_v32 = {16'd0, r_v};
    always_comb begin
        w_scale = SCALE_MIN;
        if (w_v32 >= V_MAX) begin
            w_scale = SCALE_MAX;
        end else if (w_v32 > V_MIN) begin
            w_scale = SCALE_MIN + ((w_v32 - V_MIN) * (SCALE_MAX - SCALE_MIN)) / (V_MAX - V_MIN);
        end
    end

    // Adding half the divisor turns the truncating divide into round-half-up.
    assign w_den = DEN_W'(w_scale * REF_VOLTAGE);
    assign w_num = NUM_W'(w_v32 * SCALE_BASE * DAC_MAX + (32'(w_den) >> 1));

    seq_divider u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (r_state == PREP),
        .i_dividend (w_num),
        .i_divisor  (w_den),
        .o_quotient (w_quotient),
        .o_done     (w_div_done)
    );

    assign w_code = (w_quotient > NUM_W'(DAC_MAX)) ? 8'(DAC_MAX) : w_quotient[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = PREP;
            PREP:    w_next = DIV;
            DIV:     if (w_div_done) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_clip_pend <= 1'b0;
            r_dac_code  <= '0;
            r_dac_valid <= 1'b0;
            r_clipped   <= 1'b0;
        end else begin
            r_dac_valid <= 1'b0;
            if (w_accept) begin
                r_v         <= w_over ? 16'(REF_VOLTAGE) : bus.voltage_in;
                r_clip_pend <= w_over;
            end
            if (r_state == DONE) begin
                r_dac_code  <= w_code;
                r_clipped   <= r_clip_pend;
                r_dac_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.dac_code  = r_dac_code;
    assign bus.dac_valid = r_dac_valid;
    assign bus.clipped   = r_clipped;

endmodule

// File: tb/tb_voltage_to_dac_code.sv
// tb/tb_voltage_to_dac_code.sv - self-checking bench for voltage_to_dac_code
module tb_voltage_to_dac_code;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    voltage_to_dac_code_if bus ();

    voltage_to_dac_code dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: clamp, interpolate factor, rounded ratio, saturate.
    function automatic void ref_model(input int unsigned vin, output int unsigned code,
                                      output int unsigned clip);
        int unsigned v, s, d, n;
        clip = (vin > 500) ? 1 : 0;
        v    = (vin > 500) ? 500 : vin;
        if (v <= 100)      s = 132;
        else if (v >= 500) s = 133;
        else               s = 132 + (v - 100) * (133 - 132) / (500 - 100);
        d    = s * 500;
        n    = v * 100 * 255 + d / 2;
        code = n / d;
        if (code > 255) code = 255;
    endfunction

    // One request; optionally pulses a second request during DIV that must be ignored.
    task automatic do_conv(input int unsigned v, input bit inject);
        int unsigned ec, eclip;
        int          cyc;
        bit          seen, busy_ok;
        int          extra;
        ref_model(v, ec, eclip);
        cyc = 0;
        while (!bus.in_ready && cyc < 40) begin tick(); cyc++; end
        check($sformatf("ready_before_v%0d", v), bus.in_ready, 1);
        bus.voltage_in = 16'(v);
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid   = 1'b0;
        check($sformatf("busy_after_hs_v%0d", v), bus.in_ready, 0);
        seen = 0; busy_ok = 1; cyc = 0;
        while (!seen && cyc < 40) begin
            if (inject && cyc == 12) begin
                bus.voltage_in = 16'd250;
                bus.in_valid   = 1'b1;
            end
            tick();
            cyc++;
            bus.in_valid = 1'b0;
            if (bus.dac_valid) seen = 1;
            else if (bus.in_ready) busy_ok = 0;
        end
        check($sformatf("latency_v%0d", v), cyc, 26);
        check($sformatf("busy_held_v%0d", v), busy_ok, 1);
        check($sformatf("code_v%0d", v), bus.dac_code, ec);
        check($sformatf("clipped_v%0d", v), bus.clipped, eclip);
        tick();
        check($sformatf("strobe_one_cycle_v%0d", v), bus.dac_valid, 0);
        check($sformatf("code_held_v%0d", v), bus.dac_code, ec);
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (bus.dac_valid) extra++;
            end
            check("ignored_request_no_extra_valid", extra, 0);
        end
    endtask

    initial begin
        int unsigned q_code[$];
        int unsigned q_clip[$];
        int          hs_cycle[$];
        int unsigned ec, eclip;
        int          extra;
        int          last_hs;
        int          spacing_bad;

        bus.voltage_in = '0;
        bus.in_valid   = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        check("reset_dac_code", bus.dac_code, 0);
        check("reset_dac_valid", bus.dac_valid, 0);
        check("reset_clipped", bus.clipped, 0);
        check("reset_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        tick();

        // Directed values and boundaries.
        do_conv(0, 0);
        do_conv(330, 0);
        check("directed_330", bus.dac_code, 128);
        do_conv(500, 0);
        check("directed_500", bus.dac_code, 192);
        do_conv(100, 0);
        check("directed_100", bus.dac_code, 39);
        do_conv(600, 0);
        check("directed_600_code", bus.dac_code, 192);
        check("directed_600_clip", bus.clipped, 1);
        do_conv(330, 0);
        check("clip_clears", bus.clipped, 0);
        do_conv(101, 0);
        do_conv(499, 0);
        do_conv(501, 0);
        do_conv(65535, 0);

        // Request pulsed during DIV is ignored.
        do_conv(330, 1);

        // Reset in the middle of DIV aborts the conversion.
        do_conv(600, 0);
        bus.voltage_in = 16'd330;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid   = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_dac_valid", bus.dac_valid, 0);
        check("midreset_dac_code", bus.dac_code, 0);
        check("midreset_clipped", bus.clipped, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.dac_valid) extra++;
        end
        check("midreset_no_valid", extra, 0);
        do_conv(330, 0);

        // Random single conversions.
        for (int i = 0; i < 8; i++) do_conv($urandom_range(0, 1000), 0);

        // in_valid held high with voltage_in changing every cycle: back-to-back scoreboard.
        last_hs     = -1;
        spacing_bad = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 27 * 5 + 3; c++) begin
            bus.voltage_in = 16'($urandom_range(0, 700));
            if (bus.in_ready) begin
                ref_model(bus.voltage_in, ec, eclip);
                q_code.push_back(ec);
                q_clip.push_back(eclip);
                if (last_hs >= 0 && c - last_hs != 27) spacing_bad++;
                last_hs = c;
                hs_cycle.push_back(c);
            end
            tick();
            if (bus.dac_valid) begin
                if (q_code.size() == 0) begin
                    check("b2b_unexpected_valid", 1, 0);
                end else begin
                    check("b2b_code", bus.dac_code, q_code.pop_front());
                    check("b2b_clipped", bus.clipped, q_clip.pop_front());
                end
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && q_code.size() != 0; i++) begin
            tick();
            if (bus.dac_valid) begin
                check("b2b_drain_code", bus.dac_code, q_code.pop_front());
                check("b2b_drain_clipped", bus.clipped, q_clip.pop_front());
            end
        end
        check("b2b_all_results", q_code.size(), 0);
        check("b2b_handshake_spacing", spacing_bad, 0);
        check("b2b_handshake_count", hs_cycle.size(), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
